mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage between EX and WB; consumes the registered EX output (interconnection_struct).
//  Issues load/store requests to the data memory over a req/gnt/rvalid handshake.
//  Formats load data and passes non-memory instructions through.
//  Drives o_mem_ready back to EX and o_mem_rd to the EX stall controller.
// PARAMETERS
//  XLEN         64   data/address width; byte-enable width is XLEN/8
//  RESP_TIMEOUT 255  max cycles in WAIT before a load is forced to complete with error
// PORTS
//  clk           in   1        clock, all state on rising edge
//  rst           in   1        synchronous, active-high reset
//  i_ex2all      in   struct   EX result; uses is_valid, rf_wr_en, rf_wr_addr, alu_result, mem_rd_en,
//                              mem_wr_en, mem_size[1:0], mem_unsigned, rs2_data
//  o_mem_ready   out  1        MEM accepts i_ex2all this cycle; EX holds i_ex2all while low
//  o_mem_rd      out  `ALEN    rf_wr_addr of the valid, writing instruction held in MEM, else 0
//  o_dmem_req    out  1        memory request, held until i_dmem_gnt
//  o_dmem_we     out  1        1 = store
//  o_dmem_addr   out  XLEN     alu_result with [2:0] cleared
//  o_dmem_wdata  out  XLEN     store data replicated into the addressed lane
//  o_dmem_be     out  XLEN/8   byte enables
//  i_dmem_gnt    in   1        request accepted
//  i_dmem_rvalid in   1        load data valid
//  i_dmem_rdata  in   XLEN     load data, full aligned word
//  o_mem2all     out  struct   to WB; load result in alu_result; is_valid=0 for bubbles
//  o_mem_err     out  1        one-cycle pulse with the o_mem2all of a faulted access
// BEHAVIOUR
//  - Reset: state=IDLE, o_mem2all=0, o_mem_err=0, o_dmem_req=0, held instr cleared, o_mem_rd=0, timer=0.
//  - FSM IDLE/REQ/WAIT.
//    - o_mem_ready = (state==IDLE); input captured only when ready.
//    - IDLE, valid non-mem instr: registered to o_mem2all next edge (1-cycle latency), stay IDLE.
//    - IDLE, valid mem op (rd_en|wr_en): capture, go REQ; o_mem2all.is_valid=0 (bubble).
//    - REQ: o_dmem_req=1, addr/we/be/wdata stable.
//      - Gnt on a store: o_mem2all valid next edge, go IDLE.
//      - Gnt on a load: go WAIT, timer=0.
//      - Gnt and rvalid in the same cycle: the load completes directly, skipping WAIT.
//    - WAIT: on rvalid, formatted data goes to o_mem2all.alu_result next edge, go IDLE.
//      - Timer increments each cycle. At timer==RESP_TIMEOUT: complete with data 0, o_mem_err=1, go IDLE.
//  - Size 0/1/2/3 = byte/half/word/double; lane = addr[2:0].
//    - Load: extract lane, sign-extend to XLEN, or zero-extend if mem_unsigned.
//    - Store: be = ((1<<(1<<size))-1)<<addr[2:0], wdata = rs2_data shifted by 8*addr[2:0].
//  - rvalid outside WAIT/REQ-load is ignored. Gnt outside REQ is ignored.
//  - rd_en and wr_en both set: treated as a store.
//  - o_mem_rd: nonzero from capture until completion, while the held instr is valid with rf_wr_en.
//  - Reset mid-access: req drops at that edge, FSM goes IDLE; a late rvalid is ignored.
//  - Bubbles always carry is_valid=0; all other fields are don't-care.
// CONFIGURATION
//  MEM_MISALIGN_CHECK_EN defined:
//    - Capture-time check; size 1 needs addr[0]=0, size 2 needs addr[1:0]=0, size 3 needs addr[2:0]=0.
//    - A misaligned access skips REQ; no o_dmem_req is issued.
//    - Completes next cycle with o_mem_err=1, rf_wr_en cleared in o_mem2all.
//  Undefined: no check; the lane shift uses addr[2:0] as-is and the be mask is truncated to XLEN/8 bits.
// TESTING
//  - ALU op (rd=5, alu_result=0x1234), no mem -> next cycle o_mem2all valid, alu_result=0x1234, no req.
//  - LB addr=0x1003, rdata byte3=0x80 -> alu_result=0xFFFF_FFFF_FFFF_FF80; LBU -> 0x80.
//    o_mem_rd=rd during REQ/WAIT.
//  - SH addr=0x1006 rs2=0xBEEF, gnt 3 cycles late:
//    - req held 3 cycles, be=0xC0, wdata[63:48]=0xBEEF;
//    - o_mem_ready low until completion.
//  - LD with gnt+rvalid same cycle -> result next edge; LD with no rvalid -> o_mem_err after 255 WAIT cycles.
//  - rst asserted in WAIT, then rvalid -> IDLE, no o_mem2all valid, o_mem_rd=0.
//  - MEM_MISALIGN_CHECK_EN, LW addr=0x1002 -> no req, o_mem_err=1 next cycle, rf_wr_en=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory request/response bundle between the MEM stage (master) and the data memory (slave).
// The request side is held stable while req is high; the memory answers with gnt, then rvalid/rdata.
interface mem_stage_if #(
  parameter int XLEN = 64
) ();
  logic              req;
  logic              we;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic [XLEN/8-1:0] be;
  logic              gnt;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage.sv
// MEM stage between EX and WB: issues loads/stores over req/gnt/rvalid, formats load data, passes ALU ops.
// Optional: `define MEM_MISALIGN_CHECK_EN to fault misaligned half/word/double accesses at capture time.
package mem_stage_pkg;
  localparam int XLEN = 64;
  localparam int ALEN = 5;

  typedef struct packed {
    logic            is_valid;
    logic            rf_wr_en;
    logic [ALEN-1:0] rf_wr_addr;
    logic [XLEN-1:0] alu_result;
    logic            mem_rd_en;
    logic            mem_wr_en;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic [XLEN-1:0] rs2_data;
  } interconnection_struct;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int RESP_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  interconnection_struct i_ex2all,
  output logic                  o_mem_ready,
  output logic [ALEN-1:0]       o_mem_rd,
  mem_stage_if.master           dmem,
  output interconnection_struct o_mem2all,
  output logic                  o_mem_err
);

  localparam int BEW = XLEN / 8;
  localparam int TW  = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e                state_q;
  interconnection_struct hold_q;
  interconnection_struct out_q;
  logic                  err_q;
  logic                  req_q;
  logic [TW-1:0]         timer_q;

  logic [2:0]  lane;
  logic [5:0]  lane_sh;
  logic [3:0]  nbytes;
  logic [15:0] be_wide;

  assign lane    = hold_q.alu_result[2:0];
  assign lane_sh = {lane, 3'b000};
  assign nbytes  = 4'd1 << hold_q.mem_size;
  // Mask is built wide and truncated, so unaligned lanes simply lose the upper bytes.
  assign be_wide = ((16'd1 << nbytes) - 16'd1) << lane;

  assign dmem.req   = req_q;
  assign dmem.we    = hold_q.mem_wr_en;
  assign dmem.addr  = {hold_q.alu_result[XLEN-1:3], 3'b000};
  assign dmem.wdata = hold_q.rs2_data << lane_sh;
  assign dmem.be    = be_wide[BEW-1:0];

  assign o_mem_ready = (state_q == IDLE);
  assign o_mem_rd    = (state_q != IDLE && hold_q.is_valid && hold_q.rf_wr_en) ? hold_q.rf_wr_addr : '0;
  assign o_mem2all   = out_q;
  assign o_mem_err   = err_q;

  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] word, input logic [2:0] ln,
                                               input logic [1:0] sz, input logic uns);
    logic [XLEN-1:0] s;
    s = word >> {ln, 3'b000};
    case (sz)
      2'd0:    fmt_load = uns ? {{(XLEN-8){1'b0}}, s[7:0]}   : {{(XLEN-8){s[7]}}, s[7:0]};
      2'd1:    fmt_load = uns ? {{(XLEN-16){1'b0}}, s[15:0]} : {{(XLEN-16){s[15]}}, s[15:0]};
      2'd2:    fmt_load = uns ? {{(XLEN-32){1'b0}}, s[31:0]} : {{(XLEN-32){s[31]}}, s[31:0]};
      default: fmt_load = s;
    endcase
  endfunction

`ifdef MEM_MISALIGN_CHECK_EN
  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
    case (sz)
      2'd1:    misaligned = a[0] != 1'b0;
      2'd2:    misaligned = a[1:0] != 2'b00;
      2'd3:    misaligned = a != 3'b000;
      default: misaligned = 1'b0;
    endcase
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      out_q.is_valid <= 1'b0;
      err_q          <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_ex2all.is_valid) begin
            if (i_ex2all.mem_rd_en || i_ex2all.mem_wr_en) begin
`ifdef MEM_MISALIGN_CHECK_EN
              if (misaligned(i_ex2all.mem_size, i_ex2all.alu_result[2:0])) begin
                out_q          <= i_ex2all;
                out_q.rf_wr_en <= 1'b0;
                err_q          <= 1'b1;
              end else
`endif
              begin
                hold_q  <= i_ex2all;
                req_q   <= 1'b1;
                state_q <= REQ;
              end
            end else begin
              out_q <= i_ex2all;
            end
          end
        end
        REQ: begin
          if (dmem.gnt) begin
            req_q <= 1'b0;
            if (hold_q.mem_wr_en) begin
              out_q   <= hold_q;
              state_q <= IDLE;
            end else if (dmem.rvalid) begin
              out_q            <= hold_q;
              out_q.alu_result <= fmt_load(dmem.rdata, lane, hold_q.mem_size, hold_q.mem_unsigned);
              state_q          <= IDLE;
            end else begin
              timer_q <= '0;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem.rvalid) begin
            out_q            <= hold_q;
            out_q.alu_result <= fmt_load(dmem.rdata, lane, hold_q.mem_size, hold_q.mem_unsigned);
            state_q          <= IDLE;
          end else if (timer_q == TW'(RESP_TIMEOUT)) begin
            out_q            <= hold_q;
            out_q.alu_result <= '0;
            err_q            <= 1'b1;
            state_q          <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: literal directed cases, then random traffic against a byte-level memory model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  interconnection_struct ex, wb;
  logic                  ready, merr;
  logic [ALEN-1:0]       mrd;

  mem_stage_if #(.XLEN(XLEN)) dm ();

  mem_stage #(.RESP_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_ex2all(ex), .o_mem_ready(ready), .o_mem_rd(mrd),
    .dmem(dm.master), .o_mem2all(wb), .o_mem_err(merr)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (byte-level) ----------------
  logic [63:0] mem [int unsigned];

  function automatic logic [63:0] mem_word(input int unsigned key);
    if (!mem.exists(key)) mem[key] = {key * 32'h9E3779B9, ~key};
    return mem[key];
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] word, input int lane, input int size, input bit uns);
    int n = 1 << size;
    logic [63:0] v = '0;
    for (int b = 0; b < n; b++) if (lane + b < 8) v[8*b +: 8] = word[8*(lane+b) +: 8];
    if (!uns && n < 8 && v[8*n-1]) for (int b = n; b < 8; b++) v[8*b +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] ref_be(input int lane, input int n);
    logic [7:0] be = '0;
    for (int b = 0; b < 8; b++) be[b] = (b >= lane) && (b < lane + n);
    return be;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] d, input int lane);
    logic [63:0] w = '0;
    for (int b = lane; b < 8; b++) w[8*b +: 8] = d[8*(b-lane) +: 8];
    return w;
  endfunction

  // ---------------- directed access helper ----------------
  int                    d_lat, d_req_cyc, d_ready_busy;
  logic [ALEN-1:0]       d_rd;
  bit                    d_valid, d_err, d_we;
  interconnection_struct d_out;
  logic [7:0]            d_be;
  logic [63:0]           d_wdata, d_addr;

  // gnt_at: REQ cycle (1-based) given gnt; rv_at: WAIT cycle given rvalid, 0 = never.
  task automatic access(input interconnection_struct ins, input int gnt_at, input int rv_at,
                        input bit same, input logic [63:0] rdata, input int limit);
    int  req_cyc = 0;
    int  wait_cyc = 0;
    bit  granted_load = 0;
    ex = ins;
    @(negedge clk);
    ex = '0;
    d_lat = 0; d_ready_busy = 0; d_rd = '0; d_valid = 0; d_err = 0; d_out = '0;
    d_be = '0; d_wdata = '0; d_addr = '0; d_we = 0;
    for (int c = 1; c <= limit; c++) begin
      d_lat = c;
      dm.gnt = 1'b0; dm.rvalid = 1'b0;
      if (wb.is_valid) begin
        d_valid = 1; d_out = wb; d_err = merr;
        break;
      end
      if (ready) d_ready_busy++;
      if (mrd != '0) d_rd = mrd;
      if (dm.req) begin
        req_cyc++;
        d_be = dm.be; d_wdata = dm.wdata; d_addr = dm.addr; d_we = dm.we;
        if (req_cyc == gnt_at) begin
          dm.gnt = 1'b1;
          if (!dm.we) begin
            if (same) begin dm.rvalid = 1'b1; dm.rdata = rdata; end
            else granted_load = 1;
          end
        end
      end else if (granted_load) begin
        wait_cyc++;
        if (wait_cyc == rv_at) begin dm.rvalid = 1'b1; dm.rdata = rdata; granted_load = 0; end
      end
      @(negedge clk);
    end
    d_req_cyc = req_cyc;
    dm.gnt = 1'b0; dm.rvalid = 1'b0;
  endtask

  function automatic interconnection_struct mk(input bit rd_en, input bit wr_en, input int size, input bit uns,
                                               input int rd, input logic [63:0] addr, input logic [63:0] rs2);
    interconnection_struct s = '0;
    s.is_valid = 1; s.rf_wr_en = (rd != 0); s.rf_wr_addr = ALEN'(rd); s.alu_result = addr;
    s.mem_rd_en = rd_en; s.mem_wr_en = wr_en; s.mem_size = 2'(size); s.mem_unsigned = uns; s.rs2_data = rs2;
    return s;
  endfunction

  // ---------------- random phase state ----------------
  interconnection_struct exp_q[$];
  bit                    exp_err_q[$];
  logic [63:0]           rq_addr[$], rq_wd[$];
  bit                    rq_we[$];
  logic [7:0]            rq_be[$];
  bit                    busy = 0;
  logic [ALEN-1:0]       busy_rd = '0;
  bit                    in_req = 0, pending = 0;
  int                    gnt_cnt = 0, rv_cnt = 0;
  int unsigned           pend_key = 0;

  task automatic issue(input interconnection_struct ins);
    interconnection_struct e;
    int lane, n;
    bit mis;
    e = ins;
    lane = int'(ins.alu_result[2:0]);
    n = 1 << ins.mem_size;
    mis = 0;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = (lane % n) != 0;
`endif
    if (!(ins.mem_rd_en || ins.mem_wr_en)) begin
      exp_q.push_back(e); exp_err_q.push_back(0);
    end else if (mis) begin
      e.rf_wr_en = 0;
      exp_q.push_back(e); exp_err_q.push_back(1);
    end else begin
      busy = 1;
      busy_rd = ins.rf_wr_en ? ins.rf_wr_addr : '0;
      rq_addr.push_back({ins.alu_result[63:3], 3'b000});
      rq_we.push_back(ins.mem_wr_en);
      rq_be.push_back(ref_be(lane, n));
      rq_wd.push_back(ref_wdata(ins.rs2_data, lane));
      if (!ins.mem_wr_en)
        e.alu_result = ref_load(mem_word(32'(ins.alu_result >> 3)), lane, int'(ins.mem_size), ins.mem_unsigned);
      exp_q.push_back(e); exp_err_q.push_back(0);
    end
  endtask

  // One cycle at the falling edge: compare, respond as memory, then drive EX.
  task automatic rand_step(input bit allow_issue);
    interconnection_struct e, ins;
    bit ee, rw;
    int r;
    int unsigned key;
    logic [63:0] w;
    if (wb.is_valid) begin
      if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        e = exp_q.pop_front(); ee = exp_err_q.pop_front();
        chk("out_alu", wb.alu_result, e.alu_result);
        chk("out_rs2", wb.rs2_data, e.rs2_data);
        chk("out_ctl", {wb.rf_wr_en, wb.rf_wr_addr, wb.mem_rd_en, wb.mem_wr_en, wb.mem_size, wb.mem_unsigned},
                       {e.rf_wr_en, e.rf_wr_addr, e.mem_rd_en, e.mem_wr_en, e.mem_size, e.mem_unsigned});
        chk("out_err", merr, ee);
        if (busy) begin busy = 0; busy_rd = '0; end
      end
    end else if (merr) chk("err_without_valid", merr, 0);
    chk("mem_rd", mrd, busy ? busy_rd : '0);
    chk("ready", ready, !busy);

    dm.gnt = 1'b0; dm.rvalid = 1'b0; dm.rdata = {$urandom, $urandom};
    if (dm.req) begin
      if (!in_req) begin in_req = 1; gnt_cnt = $urandom_range(0, 3); end
      if (gnt_cnt == 0) begin
        in_req = 0; dm.gnt = 1'b1;
        if (rq_addr.size() == 0) chk("unexpected_req", 1, 0);
        else begin
          rw = rq_we.pop_front();
          chk("req_addr", dm.addr, rq_addr.pop_front());
          chk("req_we", dm.we, rw);
          if (rw) begin
            chk("req_be", dm.be, rq_be.pop_front());
            chk("req_wdata", dm.wdata, rq_wd.pop_front());
          end else begin
            void'(rq_be.pop_front()); void'(rq_wd.pop_front());
          end
        end
        key = 32'(dm.addr >> 3);
        if (dm.we) begin
          w = mem_word(key);
          for (int b = 0; b < 8; b++) if (dm.be[b]) w[8*b +: 8] = dm.wdata[8*b +: 8];
          mem[key] = w;
        end else if ($urandom_range(0, 3) == 0) begin
          dm.rvalid = 1'b1; dm.rdata = mem_word(key);
        end else begin
          pending = 1; pend_key = key; rv_cnt = $urandom_range(0, 4);
        end
      end else gnt_cnt--;
    end else if (pending) begin
      if (rv_cnt == 0) begin dm.rvalid = 1'b1; dm.rdata = mem_word(pend_key); pending = 0; end
      else rv_cnt--;
    end else if (ready) begin
      r = $urandom_range(0, 9);
      if (r == 0) dm.rvalid = 1'b1;
      else if (r == 1) dm.gnt = 1'b1;
    end

    if (!busy) begin
      if (allow_issue) begin
        r = $urandom_range(0, 99);
        ins = '0;
        ins.is_valid = (r >= 10);
        ins.rf_wr_en = 1'($urandom_range(0, 1));
        ins.rf_wr_addr = ALEN'($urandom);
        ins.alu_result = {$urandom, $urandom};
        ins.rs2_data = {$urandom, $urandom};
        ins.mem_size = 2'($urandom);
        ins.mem_unsigned = 1'($urandom);
        r = $urandom_range(0, 99);
        if (r >= 40) begin
          ins.alu_result = 64'h1000 + 64'($urandom_range(0, 63));
          ins.mem_rd_en = (r < 70) || (r >= 95);
          ins.mem_wr_en = (r >= 70);
        end
        ex = ins;
        if (ins.is_valid) issue(ins);
      end else ex = '0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    interconnection_struct ins;
    rst = 1'b1; ex = '0;
    dm.gnt = 1'b0; dm.rvalid = 1'b0; dm.rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", wb.is_valid, 0);
    chk("rst_err", merr, 0);
    chk("rst_req", dm.req, 0);
    chk("rst_mem_rd", mrd, 0);
    chk("rst_ready", ready, 1);
    rst = 1'b0;

    chk("pin_ref_lb", ref_load(64'h0011_2233_8077_6655, 3, 0, 0), 64'hFFFF_FFFF_FFFF_FF80);
    chk("pin_ref_be", ref_be(6, 2), 8'hC0);
    chk("pin_ref_wd", ref_wdata(64'hBEEF, 6), 64'hBEEF_0000_0000_0000);

    // ALU pass-through
    access(mk(0, 0, 0, 0, 5, 64'h1234, 0), 1, 0, 0, 0, 10);
    chk("alu_valid", d_valid, 1); chk("alu_lat", d_lat, 1);
    chk("alu_result", d_out.alu_result, 64'h1234); chk("alu_rd", d_out.rf_wr_addr, 5);
    chk("alu_noreq", d_req_cyc, 0);
    @(negedge clk);
    chk("bubble", wb.is_valid, 0);

    // LB / LBU at 0x1003, byte 3 = 0x80
    access(mk(1, 0, 0, 0, 7, 64'h1003, 0), 1, 2, 0, 64'h0011_2233_8077_6655, 20);
    chk("lb_valid", d_valid, 1); chk("lb_data", d_out.alu_result, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_lat", d_lat, 4); chk("lb_rd", d_rd, 7); chk("lb_addr", d_addr, 64'h1000);
    chk("lb_be", d_be, 8'h08); chk("lb_ready_low", d_ready_busy, 0); chk("lb_err", d_err, 0);
    access(mk(1, 0, 0, 1, 7, 64'h1003, 0), 1, 1, 0, 64'h0011_2233_8077_6655, 20);
    chk("lbu_data", d_out.alu_result, 64'h80);

    // SH at 0x1006, gnt in the 3rd REQ cycle
    access(mk(0, 1, 1, 0, 0, 64'h1006, 64'hBEEF), 3, 0, 0, 0, 20);
    chk("sh_valid", d_valid, 1); chk("sh_req_cycles", d_req_cyc, 3); chk("sh_be", d_be, 8'hC0);
    chk("sh_wdata", d_wdata[63:48], 16'hBEEF); chk("sh_we", d_we, 1); chk("sh_lat", d_lat, 4);
    chk("sh_ready_low", d_ready_busy, 0);

    // LD with gnt and rvalid together
    access(mk(1, 0, 3, 0, 3, 64'h1008, 0), 1, 0, 1, 64'hDEAD_BEEF_CAFE_F00D, 20);
    chk("ld_same_lat", d_lat, 2); chk("ld_same_data", d_out.alu_result, 64'hDEAD_BEEF_CAFE_F00D);
    chk("ld_same_err", d_err, 0);

    // LD with no response: 1 REQ cycle, TO+1 WAIT cycles, result on the next edge
    access(mk(1, 0, 3, 0, 4, 64'h1010, 0), 1, 0, 0, 0, TO + 20);
    chk("ld_to_valid", d_valid, 1); chk("ld_to_lat", d_lat, TO + 3);
    chk("ld_to_err", d_err, 1); chk("ld_to_data", d_out.alu_result, 0);

    // Reset while waiting for load data
    ins = mk(1, 0, 3, 0, 9, 64'h1010, 0);
    ex = ins; @(negedge clk); ex = '0;
    chk("rw_req", dm.req, 1);
    dm.gnt = 1'b1; @(negedge clk); dm.gnt = 1'b0;
    chk("rw_rd", mrd, 9); chk("rw_ready", ready, 0);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("rw_req_drop", dm.req, 0); chk("rw_rd_clr", mrd, 0); chk("rw_ready_idle", ready, 1);
    dm.rvalid = 1'b1; dm.rdata = 64'h1234_5678; @(negedge clk); dm.rvalid = 1'b0;
    chk("rw_no_out", wb.is_valid, 0); chk("rw_no_err", merr, 0);
    @(negedge clk);
    chk("rw_no_out2", wb.is_valid, 0);

    // LW at 0x1002
    access(mk(1, 0, 2, 0, 6, 64'h1002, 0), 1, 1, 0, 64'h1122_3344_5566_7788, 20);
`ifdef MEM_MISALIGN_CHECK_EN
    chk("lw_mis_noreq", d_req_cyc, 0); chk("lw_mis_lat", d_lat, 1);
    chk("lw_mis_err", d_err, 1); chk("lw_mis_wen", d_out.rf_wr_en, 0);
`else
    chk("lw_un_be", d_be, 8'h3C); chk("lw_un_lat", d_lat, 3);
    chk("lw_un_data", d_out.alu_result, 64'h3344_5566); chk("lw_un_err", d_err, 0);
`endif

    // Random traffic against the model
    rst = 1'b1; ex = '0; @(negedge clk); @(negedge clk); rst = 1'b0;
    mem.delete();
    for (int c = 0; c < 3000; c++) begin
      rand_step(1);
      @(negedge clk);
    end
    for (int c = 0; c < 200 && (exp_q.size() != 0 || busy); c++) begin
      rand_step(0);
      @(negedge clk);
    end
    chk("drain_out_empty", exp_q.size(), 0);
    chk("drain_req_empty", rq_addr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
